// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point constants and FSM/segment types for the activation blocks.
// Constants are functions of the fractional width so any Qm.n format works.
package nn_fixed_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} act_state_t;

  typedef enum logic [1:0] {SEG_LO, SEG_MID, SEG_HI, SEG_SAT} seg_t;

  function automatic int ONE(input int fb);
    return 1 << fb;
  endfunction

  function automatic int FIVE(input int fb);
    return 5 << fb;
  endfunction

  // 2.375 = 19/8
  function automatic int BP_2375(input int fb);
    return 19 << (fb - 3);
  endfunction

  // 0.84375 = 27/32
  function automatic int C_084375(input int fb);
    return 27 << (fb - 5);
  endfunction

  function automatic int C_0625(input int fb);
    return 5 << (fb - 3);
  endfunction

  function automatic int C_05(input int fb);
    return 1 << (fb - 1);
  endfunction

endpackage

// File: rtl/sigmoid_plan.sv
// Two-stage PLAN sigmoid element unit: stage 1 registers |x|, sign and segment,
// stage 2 (combinational from stage 1) does shift+add and folds negative inputs.
module sigmoid_plan
  import nn_fixed_pkg::*;
#(
  parameter int bits            = 16,
  parameter int fractional_bits = 11,
  parameter int tag_w           = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic signed [bits-1:0]  x_i,
  input  logic                    valid_i,
  input  logic        [tag_w-1:0] tag_i,
  output logic        [bits-1:0]  y_o,
  output logic                    valid_o,
  output logic        [tag_w-1:0] tag_o
);

  localparam logic [bits:0] ONE_W  = (bits+1)'(ONE(fractional_bits));
  localparam logic [bits:0] FIVE_W = (bits+1)'(FIVE(fractional_bits));
  localparam logic [bits:0] BP_W   = (bits+1)'(BP_2375(fractional_bits));
  localparam logic [bits:0] C_HI_W = (bits+1)'(C_084375(fractional_bits));
  localparam logic [bits:0] C_MD_W = (bits+1)'(C_0625(fractional_bits));
  localparam logic [bits:0] C_LO_W = (bits+1)'(C_05(fractional_bits));

  logic [bits:0]    x_ext;
  logic [bits:0]    a_d, a_q;
  logic             neg_d, neg_q;
  seg_t             seg_d, seg_q;
  logic             valid_q;
  logic [tag_w-1:0] tag_q;
  logic [bits-1:0]  y_mag;

  // |x| in bits+1 so the most negative input maps to +2^(bits-1) without wrapping
  always_comb begin
    x_ext = {x_i[bits-1], x_i};
    neg_d = x_i[bits-1];
    a_d   = neg_d ? (~x_ext + 1'b1) : x_ext;
    seg_d = SEG_LO;
    if (a_d >= FIVE_W)      seg_d = SEG_SAT;
    else if (a_d >= BP_W)   seg_d = SEG_HI;
    else if (a_d >= ONE_W)  seg_d = SEG_MID;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
    end
    a_q   <= a_d;
    neg_q <= neg_d;
    seg_q <= seg_d;
    tag_q <= tag_i;
  end

  always_comb begin
    y_mag = bits'(ONE_W);
    case (seg_q)
      SEG_LO:  y_mag = bits'((a_q >> 2) + C_LO_W);
      SEG_MID: y_mag = bits'((a_q >> 3) + C_MD_W);
      SEG_HI:  y_mag = bits'((a_q >> 5) + C_HI_W);
      default: y_mag = bits'(ONE_W);
    endcase
    y_o = neg_q ? (bits'(ONE_W) - y_mag) : y_mag;
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/sigmoid_activation.sv
// Vector PLAN sigmoid between two layers: start-edge triggered, one element per cycle,
// ready held until start drops so it chains directly with layer blocks.
module sigmoid_activation
  import nn_fixed_pkg::*;
#(
  parameter int bits            = 16,
  parameter int fractional_bits = 11,
  parameter int size            = 50
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic [size-1:0][bits-1:0]   in_i,
  output logic [size-1:0][bits-1:0]   out_o,
  output logic                        ready_o
);

  localparam int            IW   = (size > 1) ? $clog2(size) : 1;
  localparam logic [IW-1:0] LAST = IW'(size - 1);

  act_state_t               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     start_q;
  logic                     ready_q;
  logic                     last_wr_q;
  logic [size-1:0][bits-1:0] out_q;

  logic [bits-1:0]          y;
  logic                     y_vld;
  logic [IW-1:0]            y_tag;

  sigmoid_plan #(
    .bits            (bits),
    .fractional_bits (fractional_bits),
    .tag_w           (IW)
  ) u_plan (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .x_i     (in_i[idx_q]),
    .valid_i (state_q == RUN),
    .tag_i   (idx_q),
    .y_o     (y),
    .valid_o (y_vld),
    .tag_o   (y_tag)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (start_i && !start_q) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (idx_q == LAST) begin
          state_d = DRAIN;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      // last_wr_q rises the cycle after the final element lands in out[]
      DRAIN: if (last_wr_q) state_d = DONE;
      DONE:  if (!start_i)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      start_q   <= 1'b0;
      ready_q   <= 1'b0;
      last_wr_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      start_q   <= start_i;
      ready_q   <= (state_d == DONE);
      last_wr_q <= y_vld && (y_tag == LAST);
      if (y_vld) out_q[y_tag] <= y;
    end
  end

  assign out_o   = out_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_sigmoid_activation.sv
// Self-checking bench for sigmoid_activation: directed tables plus random vectors
// checked against an integer-arithmetic model of the PLAN rules.
module tb_sigmoid_activation;

  localparam int BITS = 16;
  localparam int FB   = 11;
  localparam int SIZE = 50;
  localparam int LAT  = 53;
  localparam int ONE_V = 1 << FB;

  logic                      clock_i = 1'b0;
  logic                      reset_i;
  logic                      start_i;
  logic [SIZE-1:0][BITS-1:0] in_i;
  logic [SIZE-1:0][BITS-1:0] out_o;
  logic                      ready_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock_i = ~clock_i;

  sigmoid_activation #(
    .bits            (BITS),
    .fractional_bits (FB),
    .size            (SIZE)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .in_i    (in_i),
    .out_o   (out_o),
    .ready_o (ready_o)
  );

  // Reference: breakpoints and slopes written as plain rationals of 1.0
  function automatic logic [BITS-1:0] ref_sig(input logic [BITS-1:0] x);
    int xs, a, y;
    xs = int'($signed(x));
    a  = (xs < 0) ? -xs : xs;
    if (a >= 5 * ONE_V)          y = ONE_V;
    else if (8 * a >= 19 * ONE_V) y = a / 32 + (27 * ONE_V) / 32;
    else if (a >= ONE_V)         y = a / 8 + (5 * ONE_V) / 8;
    else                         y = a / 4 + ONE_V / 2;
    return BITS'((xs < 0) ? ONE_V - y : y);
  endfunction

  function automatic logic [BITS-1:0] rnd_x();
    int m;
    if ($urandom_range(0, 3) == 0) return BITS'($urandom);
    m = int'($urandom_range(0, 6 * ONE_V));
    return BITS'(($urandom_range(0, 1) == 1) ? -m : m);
  endfunction

  task automatic fill_random();
    for (int k = 0; k < SIZE; k++) in_i[k] = rnd_x();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    repeat (2) @(posedge clock_i);
    #1 reset_i = 1'b0;
  endtask

  // Starts a pass from a low start and returns edges until ready, or -1 on timeout.
  task automatic run_pass(output int lat);
    start_i = 1'b0;
    @(posedge clock_i);
    #1 start_i = 1'b1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock_i);
      #1;
      if (ready_o === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got %b want 0", ready_o);
    end
    for (int k = 0; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== '0) begin
        miscompares++;
        $display("FAIL reset_out[%0d] got %h want 0000", k, out_o[k]);
      end
    end
  endtask

  task automatic test_basic();
    logic [BITS-1:0] xin [7];
    logic [BITS-1:0] want [7];
    int lat;
    xin  = '{16'h0000, 16'h0400, 16'h0800, 16'hF800, 16'h2EE0, 16'h8000, 16'h7FFF};
    want = '{16'h0400, 16'h0500, 16'h0600, 16'h0200, 16'h0800, 16'h0000, 16'h0800};
    fill_random();
    for (int k = 0; k < 7; k++) in_i[k] = xin[k];
    run_pass(lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL basic_latency got %0d want %0d", lat, LAT);
    end
    for (int k = 0; k < 7; k++) begin
      vectors++;
      if (out_o[k] !== want[k]) begin
        miscompares++;
        $display("FAIL basic_table[%0d] got %h want %h", k, out_o[k], want[k]);
      end
    end
    for (int k = 7; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== ref_sig(in_i[k])) begin
        miscompares++;
        $display("FAIL basic_rand[%0d] x=%h got %h want %h", k, in_i[k], out_o[k], ref_sig(in_i[k]));
      end
    end
  endtask

  task automatic test_breakpoints();
    logic [BITS-1:0] xin [6];
    logic [BITS-1:0] want [6];
    int lat;
    // 2.375 -> 0.03125*2.375 + 0.84375 ; 5.0 clamps ; just below 5.0 stays on the upper line
    xin  = '{16'h1300, 16'h2800, 16'h27FF, 16'hED00, 16'hD800, 16'h0800};
    want = '{16'h0758, 16'h0800, 16'h07FF, 16'h00A8, 16'h0000, 16'h0600};
    fill_random();
    for (int k = 0; k < 6; k++) in_i[k] = xin[k];
    run_pass(lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL bp_latency got %0d want %0d", lat, LAT);
    end
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (out_o[k] !== want[k]) begin
        miscompares++;
        $display("FAIL bp[%0d] x=%h got %h want %h", k, xin[k], out_o[k], want[k]);
      end
    end
  endtask

  task automatic test_hold_start();
    logic [BITS-1:0] prev [SIZE];
    int lat;
    for (int k = 0; k < SIZE; k++) prev[k] = out_o[k];
    for (int c = 0; c < 10; c++) begin
      @(posedge clock_i);
      #1;
      vectors++;
      if (ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL hold_ready cycle %0d got %b want 1", c, ready_o);
      end
    end
    for (int k = 0; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== prev[k]) begin
        miscompares++;
        $display("FAIL hold_out[%0d] got %h want %h", k, out_o[k], prev[k]);
      end
    end
    start_i = 1'b0;
    @(posedge clock_i);
    #1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ready got %b want 0", ready_o);
    end
    fill_random();
    start_i = 1'b1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock_i);
      #1;
      if (c == 10) begin
        vectors++;
        if (out_o[SIZE-1] !== prev[SIZE-1] || ready_o !== 1'b0) begin
          miscompares++;
          $display("FAIL midpass_keep got out=%h ready=%b want out=%h ready=0",
                   out_o[SIZE-1], ready_o, prev[SIZE-1]);
        end
      end
      if (ready_o === 1'b1) begin
        lat = c;
        break;
      end
    end
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL rerun_latency got %0d want %0d", lat, LAT);
    end
    for (int k = 0; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== ref_sig(in_i[k])) begin
        miscompares++;
        $display("FAIL rerun[%0d] x=%h got %h want %h", k, in_i[k], out_o[k], ref_sig(in_i[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    fill_random();
    start_i = 1'b0;
    @(posedge clock_i);
    #1 start_i = 1'b1;
    repeat (20) @(posedge clock_i);
    #1;
    reset_i = 1'b1;
    start_i = 1'b0;
    @(posedge clock_i);
    #1;
    vectors++;
    if (ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_ready got %b want 0", ready_o);
    end
    for (int k = 0; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== '0) begin
        miscompares++;
        $display("FAIL abort_out[%0d] got %h want 0000", k, out_o[k]);
      end
    end
    reset_i = 1'b0;
    fill_random();
    run_pass(lat);
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL after_abort_latency got %0d want %0d", lat, LAT);
    end
    for (int k = 0; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== ref_sig(in_i[k])) begin
        miscompares++;
        $display("FAIL after_abort[%0d] x=%h got %h want %h", k, in_i[k], out_o[k], ref_sig(in_i[k]));
      end
    end
  endtask

  task automatic test_start_pulse();
    int lat;
    fill_random();
    start_i = 1'b0;
    @(posedge clock_i);
    #1 start_i = 1'b1;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clock_i);
      #1;
      if (ready_o === 1'b1) begin
        lat = c;
        break;
      end
      // toggles land during RUN (cycles 5..9) and DRAIN (51)
      if (c == 5 || c == 7 || c == 51) start_i = 1'b0;
      if (c == 6 || c == 9 || c == 52) start_i = 1'b1;
    end
    vectors++;
    if (lat !== LAT) begin
      miscompares++;
      $display("FAIL pulse_latency got %0d want %0d", lat, LAT);
    end
    for (int k = 0; k < SIZE; k++) begin
      vectors++;
      if (out_o[k] !== ref_sig(in_i[k])) begin
        miscompares++;
        $display("FAIL pulse[%0d] x=%h got %h want %h", k, in_i[k], out_o[k], ref_sig(in_i[k]));
      end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int p = 0; p < 4; p++) begin
      fill_random();
      run_pass(lat);
      vectors++;
      if (lat !== LAT) begin
        miscompares++;
        $display("FAIL rand_latency pass %0d got %0d want %0d", p, lat, LAT);
      end
      for (int k = 0; k < SIZE; k++) begin
        vectors++;
        if (out_o[k] !== ref_sig(in_i[k]) || out_o[k] > BITS'(ONE_V)) begin
          miscompares++;
          $display("FAIL rand[%0d][%0d] x=%h got %h want %h", p, k, in_i[k], out_o[k], ref_sig(in_i[k]));
        end
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    in_i    = '0;
    test_reset();
    test_basic();
    test_breakpoints();
    test_hold_start();
    test_reset_mid();
    test_start_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
